accum_readout: RTL and testbench
================================

// Module: accum_readout
// PURPOSE
//  Reads the adder/accumulator state out over its 8-bit result mux. On start it steps the
//  mux select through register_2 LSB, register_2 MSB, counter value and optionally counter carry.
//  It captures each byte and hands it downstream on a valid/ready byte stream.
//  Sits between the accumulator mux and the host-side byte sink. Freezes the accumulator while busy.
// PARAMETERS
//  SETTLE_CYCLES  0  extra cycles mux_sel is held before capture (0..7); allows for slow mux paths
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  start       in   1  request a readout; sampled only in IDLE
//  abort       in   1  cancel readout in progress (synchronous)
//  mux_data    in   8  data_out from accumulator result mux
//  mux_sel     out  3  select to accumulator mux; encodings from mux_sel.vh macros only
//  acc_hold    out  1  high while busy; accumulator must not update
//  byte_data   out  8  captured byte
//  byte_valid  out  1  byte_data valid
//  byte_ready  in   1  sink accepts byte when byte_valid && byte_ready at rising edge
//  byte_last   out  1  qualifies final byte of a readout (valid with byte_valid)
//  busy        out  1  FSM not in IDLE
//  done        out  1  one-cycle pulse after last byte handshake
// BEHAVIOUR
//  Reset (async assert, sync release): IDLE, mux_sel=`MUX_SEL_REGISTER_2_LSB, byte_data=0,
//  byte_valid=byte_last=busy=acc_hold=done=0, settle counter=0, byte index=0.
//  All outputs registered; mux_data treated as combinational from mux_sel.
//  Byte order: idx0 LSB, idx1 MSB, idx2 COUNTER_VALUE, idx3 COUNTER_CARRY (if enabled).
//  FSM states: IDLE, LOAD, SEND.
//  - IDLE: start && !abort -> mux_sel=idx0 select, idx=0, busy=acc_hold=1, settle cnt=0, LOAD.
//  - LOAD: if cnt<SETTLE_CYCLES, cnt++. Else byte_data<=mux_data, byte_valid<=1,
//    byte_last<=(idx==LAST), go to SEND.
//  - SEND: hold byte_data/byte_last stable while !byte_ready.
//    On handshake, byte_valid<=0. If last: done<=1, busy=acc_hold=0, mux_sel=LSB, IDLE.
//    Otherwise idx++, mux_sel=next, cnt=0, LOAD.
//  Latency: start at edge N -> byte_valid high after edge N+2+SETTLE_CYCLES.
//  Each further byte arrives 2+SETTLE_CYCLES cycles after the prior handshake.
//  Continuous ready, SETTLE=0: 4 bytes in 8 cycles (3 bytes in 6 without carry).
//  done asserts the cycle after the last handshake; busy is already 0 that cycle.
//  start while busy: ignored, not queued.
//  start on the same edge as done: ignored (FSM still in SEND). Next start is accepted from IDLE.
//  abort in LOAD/SEND: next edge -> IDLE, byte_valid=byte_last=0, mux_sel=LSB, no done pulse.
//  A byte pending in SEND is dropped. abort wins over a simultaneous handshake or start.
//  abort in IDLE: no effect.
//  rst_n low mid-readout: immediately to reset values. No partial byte survives.
//  idx never exceeds LAST. Never drive an undefined sel encoding.
// CONFIGURATION
//  ACCUM_READOUT_CARRY_EN defined: 4-byte readout, LAST=3, idx3 selects `MUX_SEL_COUNTER_CARRY.
//  The carry byte is {7'b0,carry}.
//  Not defined: 3-byte readout, LAST=2, byte_last on COUNTER_VALUE byte.
//  COUNTER_CARRY encoding is never driven.
// TESTING
//  1 Reset: assert rst_n=0 mid-SEND -> all outputs at reset values with no clock.
//    Idle after release; no spurious done.
//  2 Basic: LSB=8'h34, MSB=8'h12, counter=8'hA5, carry=1, ready=1, CARRY_EN defined.
//    start -> bytes 34,12,A5,01; byte_last on the 4th; done 1 cycle later; 8 cycles total.
//  3 Backpressure: hold ready=0 for 5 cycles on byte 2.
//    -> byte_data=8'h12 stable and valid; sel unchanged; acc_hold=1 throughout.
//  4 Abort: abort while byte 1 is valid (not yet accepted) -> next cycle valid=0, busy=0, no done.
//    A new start then gives the full sequence from LSB.
//  5 Config/settle: CARRY_EN undefined, SETTLE_CYCLES=3.
//    -> 3 bytes; first valid 5 cycles after start; mux_sel never equals COUNTER_CARRY.
//  6 Start collisions: start pulses while busy -> ignored.
//    start with abort in IDLE -> stays IDLE.

Source files
------------

// File: rtl/accum_readout_if.sv
// accum_readout_if -- downstream byte stream of the accumulator readout.
//   byte_data  [7:0]  captured byte (master -> slave)
//   byte_valid        byte_data valid (master -> slave)
//   byte_last         final byte of the readout, qualified by byte_valid (master -> slave)
//   byte_ready        sink accepts on byte_valid && byte_ready at rising edge (slave -> master)
interface accum_readout_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  modport master (output byte_data, byte_valid, byte_last, input byte_ready);
  modport slave  (input byte_data, byte_valid, byte_last, output byte_ready);
endinterface

// File: rtl/accum_readout.sv
// accum_readout -- steps the accumulator result mux through register_2 LSB,
// register_2 MSB, counter value (and counter carry when ACCUM_READOUT_CARRY_EN is
// defined), captures each byte and hands it out on a valid/ready byte stream.
// The accumulator is frozen (o_acc_hold) for the whole readout.
//
// Config macro: ACCUM_READOUT_CARRY_EN -- adds the 4th byte {7'b0,carry}.
// Parameter  : SETTLE_CYCLES (0..7) -- extra cycles mux_sel is held before capture.
//
// Ports
//   i_clk, i_rst_n   clock, async active-low reset
//   i_start          request a readout (IDLE only)
//   i_abort          cancel readout in progress
//   i_mux_data [7:0] combinational data from the accumulator mux
//   o_mux_sel  [2:0] mux select
//   o_acc_hold       accumulator must not update
//   o_busy           FSM not idle
//   o_done           one-cycle pulse after the last byte handshake
//   bs               byte stream (master)

`ifndef MUX_SEL_REGISTER_2_LSB
`define MUX_SEL_REGISTER_2_LSB 3'd0
`endif
`ifndef MUX_SEL_REGISTER_2_MSB
`define MUX_SEL_REGISTER_2_MSB 3'd1
`endif
`ifndef MUX_SEL_COUNTER_VALUE
`define MUX_SEL_COUNTER_VALUE  3'd2
`endif
`ifndef MUX_SEL_COUNTER_CARRY
`define MUX_SEL_COUNTER_CARRY  3'd3
`endif

module accum_readout #(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [7:0]            i_mux_data,
  output logic [2:0]            o_mux_sel,
  output logic                  o_acc_hold,
  output logic                  o_busy,
  output logic                  o_done,
  accum_readout_if.master       bs
);

`ifdef ACCUM_READOUT_CARRY_EN
  localparam logic [1:0] LAST = 2'd3;
`else
  localparam logic [1:0] LAST = 2'd2;
`endif
  localparam logic [2:0] SETTLE = SETTLE_CYCLES[2:0];

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  state_t     r_state,  w_state_nxt;
  logic [1:0] r_idx,    w_idx_nxt;
  logic [2:0] r_cnt,    w_cnt_nxt;
  logic [2:0] r_mux_sel, w_sel_nxt;
  logic [7:0] r_byte_data, w_data_nxt;
  logic       r_byte_valid, w_valid_nxt;
  logic       r_byte_last,  w_last_nxt;
  logic       r_busy,   w_busy_nxt;
  logic       r_done,   w_done_nxt;
  logic [1:0] w_idx_inc;

  // Byte index -> mux select. Any index outside the readout maps to LSB so an
  // undefined encoding can never reach the mux.
  function automatic logic [2:0] sel_of(input logic [1:0] idx);
    logic [2:0] s;
    s = `MUX_SEL_REGISTER_2_LSB;
    case (idx)
      2'd1:    s = `MUX_SEL_REGISTER_2_MSB;
      2'd2:    s = `MUX_SEL_COUNTER_VALUE;
`ifdef ACCUM_READOUT_CARRY_EN
      2'd3:    s = `MUX_SEL_COUNTER_CARRY;
`endif
      default: s = `MUX_SEL_REGISTER_2_LSB;
    endcase
    return s;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_mux_sel;
    w_data_nxt  = r_byte_data;
    w_valid_nxt = r_byte_valid;
    w_last_nxt  = r_byte_last;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_idx_inc   = r_idx + 2'd1;

    if (i_abort && r_state != S_IDLE) begin
      // abort beats handshake and start; any pending byte is dropped, no done
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd0;
      w_cnt_nxt   = 3'd0;
      w_sel_nxt   = `MUX_SEL_REGISTER_2_LSB;
      w_valid_nxt = 1'b0;
      w_last_nxt  = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = 3'd0;
            w_sel_nxt   = sel_of(2'd0);
            w_busy_nxt  = 1'b1;
          end
        end
        S_LOAD: begin
          if (r_cnt < SETTLE) begin
            w_cnt_nxt = r_cnt + 3'd1;
          end else begin
            w_data_nxt  = i_mux_data;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (r_idx == LAST);
            w_state_nxt = S_SEND;
          end
        end
        S_SEND: begin
          if (bs.byte_ready) begin
            w_valid_nxt = 1'b0;
            if (r_byte_last) begin
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_last_nxt  = 1'b0;
              w_idx_nxt   = 2'd0;
              w_sel_nxt   = `MUX_SEL_REGISTER_2_LSB;
              w_state_nxt = S_IDLE;
            end else begin
              w_idx_nxt   = w_idx_inc;
              w_sel_nxt   = sel_of(w_idx_inc);
              w_cnt_nxt   = 3'd0;
              w_state_nxt = S_LOAD;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_cnt        <= 3'd0;
      r_mux_sel    <= `MUX_SEL_REGISTER_2_LSB;
      r_byte_data  <= 8'd0;
      r_byte_valid <= 1'b0;
      r_byte_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mux_sel    <= w_sel_nxt;
      r_byte_data  <= w_data_nxt;
      r_byte_valid <= w_valid_nxt;
      r_byte_last  <= w_last_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign o_mux_sel     = r_mux_sel;
  assign o_acc_hold    = r_busy;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign bs.byte_data  = r_byte_data;
  assign bs.byte_valid = r_byte_valid;
  assign bs.byte_last  = r_byte_last;

endmodule

// File: tb/tb_accum_readout.sv
`timescale 1ns/1ps
module tb_accum_readout;
  localparam int SETTLE = 2;
`ifdef ACCUM_READOUT_CARRY_EN
  localparam int NBYTES = 4;
  localparam logic [2:0] SEL_MAX = 3'd3;
`else
  localparam int NBYTES = 3;
  localparam logic [2:0] SEL_MAX = 3'd2;
`endif
  localparam logic [2:0] SEL_LSB = 3'd0, SEL_MSB = 3'd1, SEL_VAL = 3'd2, SEL_CAR = 3'd3;

  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] mux_data;
  logic [2:0] mux_sel;
  logic       acc_hold, busy, done;
  accum_readout_if bs();

  accum_readout #(.SETTLE_CYCLES(SETTLE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_mux_data(mux_data), .o_mux_sel(mux_sel), .o_acc_hold(acc_hold),
    .o_busy(busy), .o_done(done), .bs(bs));

  always #5 clk = ~clk;

  // accumulator model: free-running values, frozen while held
  logic [7:0] a_lsb, a_msb, a_cnt;
  logic       a_car;
  logic       acc_rand_en = 1'b1;
  always @(negedge clk)
    if (acc_rand_en && acc_hold !== 1'b1) begin
      a_lsb = 8'($urandom); a_msb = 8'($urandom); a_cnt = 8'($urandom); a_car = 1'($urandom);
    end

  always_comb begin
    mux_data = 8'hEE;
    case (mux_sel)
      SEL_LSB: mux_data = a_lsb;
      SEL_MSB: mux_data = a_msb;
      SEL_VAL: mux_data = a_cnt;
      SEL_CAR: mux_data = {7'b0, a_car};
      default: mux_data = 8'hEE;
    endcase
  end

  typedef struct { logic [7:0] data; logic last; logic [2:0] sel; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  logic       m_busy, m_done, prev_valid, prev_last, hs;
  logic [7:0] prev_data;
  logic [2:0] prev_sel;
  int         gap;
  initial begin : monitor
    exp_t e;
    m_busy = 0; m_done = 0; prev_valid = 0; gap = 0;
    forever begin
      @(negedge clk); #2;
      if (rst_n !== 1'b1) begin
        q.delete(); m_busy = 0; m_done = 0; prev_valid = 0; gap = 0;
        continue;
      end
      gap++;
      chk("busy", busy, m_busy);
      chk("acc_hold", acc_hold, m_busy);
      chk("done", done, m_done);
      m_done = 0;
      chk("sel_legal", (mux_sel <= SEL_MAX), 1);
      if (!m_busy) chk("idle_valid", bs.byte_valid, 0);
      if (bs.byte_valid && !prev_valid) chk("latency", gap, 2 + SETTLE);
      if (prev_valid) begin
        chk("valid_held", bs.byte_valid, 1);
        chk("data_stable", bs.byte_data, prev_data);
        chk("last_stable", bs.byte_last, prev_last);
        chk("sel_stable", mux_sel, prev_sel);
      end
      if (bs.byte_valid && q.size() > 0) chk("mux_sel", mux_sel, q[0].sel);
      // events at the coming edge
      hs = bs.byte_valid && bs.byte_ready && !abort;
      prev_valid = bs.byte_valid && !hs && !(abort && m_busy);
      prev_data = bs.byte_data; prev_last = bs.byte_last; prev_sel = mux_sel;
      if (abort && m_busy) begin
        q.delete(); m_busy = 0;
      end else if (hs) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", bs.byte_data, $time);
        end else begin
          e = q.pop_front();
          chk("byte_data", bs.byte_data, e.data);
          chk("byte_last", bs.byte_last, e.last);
          if (e.last) begin m_busy = 0; m_done = 1; end
        end
        gap = 0;
      end else if (start && !abort && !m_busy) begin
        for (int i = 0; i < NBYTES; i++) begin
          case (i)
            0: begin e.data = a_lsb;         e.sel = SEL_LSB; end
            1: begin e.data = a_msb;         e.sel = SEL_MSB; end
            2: begin e.data = a_cnt;         e.sel = SEL_VAL; end
            default: begin e.data = {7'b0, a_car}; e.sel = SEL_CAR; end
          endcase
          e.last = (i == NBYTES - 1);
          q.push_back(e);
        end
        m_busy = 1; gap = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy !== 1'b0 || bs.byte_valid !== 1'b0) && k < 400) begin cyc(); k++; end
    if (k >= 400) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle_timeout: got busy=%0b expected idle", busy);
    end
    cyc(2);
  endtask

  task automatic wait_valid(input logic [2:0] sel);
    int k = 0;
    while (!(bs.byte_valid === 1'b1 && mux_sel === sel) && k < 100) begin cyc(); k++; end
    if (k >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL wait_valid_timeout: got valid=%0b sel=%0d expected sel %0d", bs.byte_valid, mux_sel, sel);
    end
  endtask

  task automatic chk_reset();
    chk("rst_mux_sel", mux_sel, SEL_LSB);
    chk("rst_byte_data", bs.byte_data, 8'h00);
    chk("rst_byte_valid", bs.byte_valid, 0);
    chk("rst_byte_last", bs.byte_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc_hold", acc_hold, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1);
  end

  initial begin : driver
    int n;
    bs.byte_ready = 1'b1;
    #1 rst_n = 0;
    #2 chk_reset();
    cyc(2); rst_n = 1; cyc(3);

    // basic readout, known values, continuous ready
    acc_rand_en = 0; cyc();
    a_lsb = 8'h34; a_msb = 8'h12; a_cnt = 8'hA5; a_car = 1'b1;
    pulse_start();
    n = 1;
    while (done !== 1'b1 && n < 300) begin cyc(); n++; end
    chk("total_cycles", n, NBYTES * (2 + SETTLE) + 1);
    wait_idle();
    acc_rand_en = 1;

    // backpressure on the MSB byte
    pulse_start();
    wait_valid(SEL_MSB);
    bs.byte_ready = 0; cyc(5); bs.byte_ready = 1;
    wait_idle();

    // abort while first byte pending, then a fresh full readout
    bs.byte_ready = 0;
    pulse_start();
    wait_valid(SEL_LSB);
    abort = 1; cyc(); abort = 0;
    cyc(2); bs.byte_ready = 1;
    pulse_start();
    wait_idle();

    // reset mid-SEND
    bs.byte_ready = 0;
    pulse_start();
    wait_valid(SEL_MSB - 3'd1);
    #3 rst_n = 0;
    #1 chk_reset();
    cyc(2); rst_n = 1; bs.byte_ready = 1; cyc(5);

    // start pulses while busy are ignored
    pulse_start();
    cyc(2); pulse_start(); cyc(1); pulse_start();
    wait_idle();

    // start coinciding with the last handshake is ignored
    pulse_start();
    cyc(NBYTES * (2 + SETTLE) - 1);
    pulse_start();
    cyc(3);
    wait_idle();

    // start together with abort in idle: stays idle
    start = 1; abort = 1; cyc(); start = 0; abort = 0; cyc(3);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bs.byte_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 40) == 0);
      cyc();
    end
    start = 0; abort = 0; bs.byte_ready = 1;
    wait_idle();
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL leftover_bytes: got %0d pending expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
